// File: rtl/spi_eeprom_pkg.sv
// Shared definitions for the SPI EEPROM responder and the program-fetch core:
// opcodes, responder state encoding and program-image layout.
package spi_eeprom_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;

  // Program image: 16-bit vector word, 16-bit end word, then instruction bytes.
  localparam int IMG_VECTOR_OFS = 'h000;
  localparam int IMG_END_OFS    = 'h002;
  localparam int IMG_CODE_OFS   = 'h004;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_READ_DATA,
    ST_WRITE_DATA,
    ST_STATUS,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/spi_eeprom_responder_spi_in_sync.sv
// Synchronizes the asynchronous SPI pins into clk and detects SCK edges
// from the synced value against one extra delay flop.
module spi_eeprom_responder_spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_sck,
  input  logic spi_cs_n,
  input  logic spi_copi,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_active,
  output logic copi_s
);

  logic [SYNC_STAGES-1:0] sck_q;
  logic [SYNC_STAGES-1:0] cs_q;
  logic [SYNC_STAGES-1:0] copi_q;
  logic                   sck_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q  <= '0;
      cs_q   <= '1;
      copi_q <= '0;
      sck_d  <= 1'b0;
    end else begin
      sck_q  <= {sck_q[SYNC_STAGES-2:0], spi_sck};
      cs_q   <= {cs_q[SYNC_STAGES-2:0], spi_cs_n};
      copi_q <= {copi_q[SYNC_STAGES-2:0], spi_copi};
      sck_d  <= sck_q[SYNC_STAGES-1];
    end
  end

  assign sck_rise  = sck_q[SYNC_STAGES-1] & ~sck_d;
  assign sck_fall  = ~sck_q[SYNC_STAGES-1] & sck_d;
  assign cs_active = ~cs_q[SYNC_STAGES-1];
  assign copi_s    = copi_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_eeprom_responder.sv
// SPI mode-0 target emulating a 25xx serial EEPROM holding the program image.
// ADDR_W must lie in 9..16: the kept address spans part of the high byte.
module spi_eeprom_responder
  import spi_eeprom_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_copi,
  output logic              spi_cipo,
  output logic              spi_cipo_oe,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int HI_W  = ADDR_W - 8;

  logic sck_rise, sck_fall, cs_active, copi_s;

  spi_eeprom_responder_spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_sck   (spi_sck),
    .spi_cs_n  (spi_cs_n),
    .spi_copi  (spi_copi),
    .sck_rise  (sck_rise),
    .sck_fall  (sck_fall),
    .cs_active (cs_active),
    .copi_s    (copi_s)
  );

  logic [7:0]        mem [DEPTH];
  state_t            state;
  logic [2:0]        bitcnt;
  logic [6:0]        in_shift;
  logic [7:0]        out_shift;
  logic [HI_W-1:0]   addr_hi;
  logic [ADDR_W-1:0] addr;
  logic              is_write;
  logic              wel;
  logic              wrote;

  logic [7:0]        byte_in;
  logic [ADDR_W-1:0] addr_full;
  logic [ADDR_W-1:0] addr_inc;
  logic              byte_done;
  logic              spi_we;

  assign byte_in   = {in_shift, copi_s};
  assign addr_full = {addr_hi, byte_in};
  assign addr_inc  = addr + ADDR_W'(1);
  assign byte_done = sck_rise && (bitcnt == 3'd7);
  assign spi_we    = cs_active && (state == ST_WRITE_DATA) && byte_done;

  // The harness load port takes priority; a colliding SPI byte is dropped.
  always_ff @(posedge clk) begin
    if (ld_we)       mem[ld_addr] <= ld_data;
    else if (spi_we) mem[addr]    <= byte_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bitcnt      <= 3'd0;
      in_shift    <= 7'd0;
      out_shift   <= 8'd0;
      addr_hi     <= '0;
      addr        <= '0;
      is_write    <= 1'b0;
      wel         <= 1'b0;
      wrote       <= 1'b0;
      spi_cipo    <= 1'b0;
      spi_cipo_oe <= 1'b0;
      busy        <= 1'b0;
    end else if (!cs_active) begin
      state       <= ST_IDLE;
      bitcnt      <= 3'd0;
      spi_cipo    <= 1'b0;
      spi_cipo_oe <= 1'b0;
      busy        <= 1'b0;
      if (wrote) begin
        wel   <= 1'b0;
        wrote <= 1'b0;
      end
    end else begin
      spi_cipo_oe <= 1'b1;
      busy        <= 1'b1;
      case (state)
        ST_IDLE: begin
          state  <= ST_CMD;
          bitcnt <= 3'd0;
        end
        ST_CMD, ST_ADDR_H, ST_ADDR_L, ST_WRITE_DATA: begin
          if (sck_rise) begin
            in_shift <= byte_in[6:0];
            bitcnt   <= bitcnt + 3'd1;
          end
          if (byte_done) begin
            case (state)
              ST_CMD: begin
                case (byte_in)
                  OP_READ: begin
                    is_write <= 1'b0;
                    state    <= ST_ADDR_H;
                  end
                  OP_WRITE: begin
                    is_write <= 1'b1;
                    state    <= wel ? ST_ADDR_H : ST_IGNORE;
                  end
                  OP_WREN: begin
                    wel   <= 1'b1;
                    state <= ST_IGNORE;
                  end
                  OP_WRDI: begin
                    wel   <= 1'b0;
                    state <= ST_IGNORE;
                  end
                  OP_RDSR: begin
                    out_shift <= {6'b0, wel, 1'b0};
                    state     <= ST_STATUS;
                  end
                  default: state <= ST_IGNORE;
                endcase
              end
              ST_ADDR_H: begin
                addr_hi <= byte_in[HI_W-1:0];
                state   <= ST_ADDR_L;
              end
              ST_ADDR_L: begin
                addr <= addr_full;
                if (is_write) begin
                  state <= ST_WRITE_DATA;
                end else begin
                  out_shift <= mem[addr_full];
                  state     <= ST_READ_DATA;
                end
              end
              default: begin
                addr  <= addr_inc;
                wrote <= 1'b1;
              end
            endcase
          end
        end
        // In the output states bitcnt counts falling edges instead.
        ST_READ_DATA, ST_STATUS: begin
          if (sck_fall) begin
            spi_cipo <= out_shift[7];
            bitcnt   <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              if (state == ST_READ_DATA) begin
                addr      <= addr_inc;
                out_shift <= mem[addr_inc];
              end else begin
                out_shift <= {6'b0, wel, 1'b0};
              end
            end else begin
              out_shift <= {out_shift[6:0], 1'b0};
            end
          end
        end
        default: spi_cipo <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_eeprom_responder.sv
// Directed and randomized SPI transactions against a byte-array EEPROM model.
module tb_spi_eeprom_responder;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam time HALF  = 40ns;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              spi_sck = 1'b0;
  logic              spi_cs_n = 1'b1;
  logic              spi_copi = 1'b0;
  logic              spi_cipo;
  logic              spi_cipo_oe;
  logic              ld_we = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [7:0]        ld_data = '0;
  logic              busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] model_mem [DEPTH];
  bit         model_wel = 1'b0;

  spi_eeprom_responder #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_copi    (spi_copi),
    .spi_cipo    (spi_cipo),
    .spi_cipo_oe (spi_cipo_oe),
    .ld_we       (ld_we),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .busy        (busy)
  );

  always #5ns clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int a, input logic [7:0] d);
    @(negedge clk);
    ld_we   = 1'b1;
    ld_addr = ADDR_W'(a);
    ld_data = d;
    model_mem[a] = d;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic begin_frame();
    spi_cs_n = 1'b0;
    #HALF;
  endtask

  task automatic end_frame();
    #HALF;
    spi_cs_n = 1'b1;
    #(4 * HALF);
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      spi_copi = tx[i];
      #HALF;
      spi_sck = 1'b1;
      rx[i]   = spi_cipo;
      #HALF;
      spi_sck = 1'b0;
    end
  endtask

  task automatic rd_check(input string tag, input int a16, input int n);
    logic [7:0] rx;
    begin_frame();
    xfer(8'h03, rx);
    xfer(a16[15:8], rx);
    xfer(a16[7:0], rx);
    for (int i = 0; i < n; i++) begin
      xfer(8'h00, rx);
      chk(tag, rx, model_mem[(a16 + i) % DEPTH]);
    end
    end_frame();
  endtask

  task automatic cmd_only(input logic [7:0] op);
    logic [7:0] rx;
    begin_frame();
    xfer(op, rx);
    end_frame();
    if (op == 8'h06) model_wel = 1'b1;
    if (op == 8'h04) model_wel = 1'b0;
  endtask

  task automatic wr(input int a16, input int n);
    logic [7:0] rx;
    logic [7:0] d;
    begin_frame();
    xfer(8'h02, rx);
    xfer(a16[15:8], rx);
    xfer(a16[7:0], rx);
    for (int i = 0; i < n; i++) begin
      d = 8'($urandom);
      xfer(d, rx);
      if (model_wel) model_mem[(a16 + i) % DEPTH] = d;
    end
    end_frame();
    if (model_wel && n > 0) model_wel = 1'b0;
  endtask

  task automatic rdsr_check(input string tag, input int n);
    logic [7:0] rx;
    begin_frame();
    xfer(8'h05, rx);
    for (int i = 0; i < n; i++) begin
      xfer(8'h00, rx);
      chk(tag, rx, {6'b0, model_wel, 1'b0});
    end
    end_frame();
  endtask

  initial begin
    logic [7:0] rx;
    int a;
    int n;
    #3ns;
    #50ns;
    chk("reset_busy", busy, 1'b0);
    chk("reset_oe", spi_cipo_oe, 1'b0);
    chk("reset_cipo", spi_cipo, 1'b0);
    rst_n = 1'b1;
    #50ns;

    for (int i = 0; i < DEPTH; i++) load(i, 8'($urandom));
    load(0, 8'h00);
    load(1, 8'h04);
    load(2, 8'h00);
    load(3, 8'h06);
    #HALF;

    // Image header straight from the preload, then two more bytes.
    begin_frame();
    chk("busy_in_frame", busy, 1'b1);
    chk("oe_in_frame", spi_cipo_oe, 1'b1);
    end_frame();
    rd_check("read_hdr", 'h0000, 6);
    rd_check("read_wrap", 'h03FF, 2);
    rd_check("read_upper_ignored", 'hFC05, 1);

    wr('h0010, 1);
    rd_check("write_no_wel", 'h0010, 1);
    cmd_only(8'h06);
    wr('h0010, 2);
    chk("model_a5_path", model_wel, 1'b0);
    rd_check("write_data", 'h0010, 2);
    rdsr_check("rdsr_after_write", 1);
    cmd_only(8'h06);
    rdsr_check("rdsr_wren", 3);
    cmd_only(8'h04);
    rdsr_check("rdsr_wrdi", 1);

    // Abort a READ opcode after five bits.
    begin_frame();
    for (int i = 7; i >= 3; i--) begin
      spi_copi = (8'h03 >> i) & 1'b1;
      #HALF; spi_sck = 1'b1;
      #HALF; spi_sck = 1'b0;
    end
    end_frame();
    rd_check("read_after_abort", 'h0002, 1);

    // Reset in the middle of a READ data byte.
    begin_frame();
    xfer(8'h03, rx);
    xfer(8'h00, rx);
    xfer(8'h04, rx);
    for (int i = 0; i < 3; i++) begin
      #HALF; spi_sck = 1'b1;
      #HALF; spi_sck = 1'b0;
    end
    #HALF;
    chk("oe_before_reset", spi_cipo_oe, 1'b1);
    rst_n = 1'b0;
    #1ns;
    chk("rst_cipo", spi_cipo, 1'b0);
    chk("rst_oe", spi_cipo_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    spi_cs_n = 1'b1;
    spi_sck  = 1'b0;
    model_wel = 1'b0;
    #20ns;
    rst_n = 1'b1;
    #(4 * HALF);
    rd_check("read_after_reset", 'h0000, 2);
    rd_check("read_after_reset_w", 'h0010, 2);

    // Unknown opcode keeps CIPO low for the whole frame.
    begin_frame();
    xfer(8'hFF, rx);
    chk("unknown_op", rx, 8'h00);
    for (int i = 0; i < 2; i++) begin
      xfer(8'($urandom), rx);
      chk("unknown_data", rx, 8'h00);
    end
    end_frame();

    for (int it = 0; it < 10; it++) begin
      a = int'($urandom_range(0, 'hFFFF));
      n = int'($urandom_range(1, 4));
      case ($urandom_range(0, 2))
        0: rd_check("rand_read", a, n);
        1: begin
          cmd_only(8'h06);
          wr(a, n);
          rd_check("rand_write", a, n);
        end
        default: begin
          wr(a, n);
          rd_check("rand_write_nowel", a, n);
        end
      endcase
      rdsr_check("rand_rdsr", 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_eeprom_responder.md
Name: spi_eeprom_responder

Overview:
- SPI mode-0 target that emulates the 25xx-style serial EEPROM holding the ladder-logic program image: vector word, end word, then instruction bytes.
- Sits at the far end of the program-fetch SPI link. It answers READ (0x03) with a 16-bit address and streaming auto-increment, so the core can run without external EEPROM in simulation and FPGA bring-up.
- Also accepts WREN/WRDI/RDSR/WRITE so a host can program the image over the same bus.
- A parallel load port preloads memory from the test harness.

Parameters:
ADDR_W, 10, memory address width; depth = 2**ADDR_W bytes
SYNC_STAGES, 2, synchronizer flops on spi_sck/spi_cs_n/spi_copi (≥2)

Ports:
clk  in  1  system clock; must be ≥4× SCK frequency
rst_n  in  1  asynchronous active-low reset
spi_sck  in  1  SPI clock from initiator, asynchronous
spi_cs_n  in  1  chip select, active low, asynchronous
spi_copi  in  1  controller-out data, asynchronous
spi_cipo  out  1  target-out data
spi_cipo_oe  out  1  high while the target drives spi_cipo (synced cs_n low)
ld_we  in  1  parallel load write strobe
ld_addr  in  ADDR_W  parallel load address
ld_data  in  8  parallel load data
busy  out  1  high while a transaction is open (synced cs_n low)

Behaviour:
- Clocking and reset:
  - Single clk domain; all flops reset asynchronously on rst_n low.
  - Reset values: spi_cipo=0, spi_cipo_oe=0, busy=0, state=IDLE, WEL=0, bit counter=0.
  - Memory contents are not reset.
- Input conditioning:
  - spi_sck, spi_cs_n and spi_copi pass through SYNC_STAGES flops.
  - Rising/falling SCK edges come from the synced value vs. one extra delay flop.
  - COPI is sampled on the synced rising edge. spi_cipo updates on the synced falling edge.
  - Latency from a pin edge to its effect is SYNC_STAGES+1 clk cycles.
- Framing:
  - Synced cs_n high forces state=IDLE, bitcnt=0, spi_cipo=0, spi_cipo_oe=0, regardless of the current state. A cs_n rise mid-byte aborts and discards partial bits.
  - Falling synced cs_n enters CMD.
  - Shift register is MSB first; a byte completes on the 8th rising edge (bitcnt wraps 7→0).
- State machine:
  - CMD: complete byte decodes as follows:
    - 0x03 → ADDR_H (READ)
    - 0x02 → ADDR_H if WEL=1, else IGNORE (WRITE)
    - 0x06 → set WEL, then IGNORE
    - 0x04 → clear WEL, then IGNORE
    - 0x05 → STATUS
    - anything else → IGNORE
  - ADDR_H → ADDR_L: the address is 16 bits; only the low ADDR_W bits are kept and the upper bits are ignored.
  - ADDR_L complete, READ:
    - load out_shift = mem[addr] on that same rising edge, go to READ_DATA.
    - spi_cipo shows bit 7 after the next falling edge.
  - READ_DATA:
    - each falling edge shifts out the next bit.
    - after bit 0 has been shifted out (8th falling edge), addr=addr+1, wrapping modulo 2**ADDR_W, and out_shift reloads from the new address in time for the following falling edge.
    - streaming continues indefinitely until cs_n rises.
  - WRITE_DATA:
    - each complete byte writes mem[addr], then addr increments with the same wrap.
    - no page limit.
    - cs_n rise clears WEL if at least one byte was written.
  - STATUS: repeatedly shifts {6'b0, WEL, WIP=0}, MSB first, until cs_n rises.
  - IGNORE: spi_cipo held 0 until cs_n rises.
- Simultaneous events:
  - ld_we and an SPI write in the same clk: ld_we wins, and the SPI byte is dropped.
  - ld_we to the address currently loaded into out_shift does not alter bits already in flight.
- Outputs:
  - spi_cipo_oe = busy = inverted synced cs_n.
  - spi_cipo is 0 whenever spi_cipo_oe is 0.

Decomposition:
- Shared package (spi_eeprom_pkg) holds:
  - opcode localparams: READ 8'h03, WRITE 8'h02, WREN 8'h06, WRDI 8'h04, RDSR 8'h05.
  - state encoding: IDLE, CMD, ADDR_H, ADDR_L, READ_DATA, WRITE_DATA, STATUS, IGNORE.
  - the program-image layout offsets (vector at 0x000, end at 0x002); the fetch core uses these too.
- One sub-module, spi_in_sync: synchronizer plus SCK edge detector, producing sck_rise, sck_fall, cs_active, copi_s.

Test Plan:
- Preload mem[0..3] = 00 04 00 06 via ld port, then READ at 0x0000 with 6 bytes clocked → CIPO returns 00 04 00 06 followed by mem[4], mem[5].
- READ at 0x03FF, 2 bytes → returns mem[0x3FF] then mem[0x000] (wrap). Address 0xFC05 → reads mem[0x005] (upper bits ignored).
- WRITE 0x02 with WEL=0 to 0x0010 data 0xA5 → mem unchanged. WREN, then WRITE 0x0010 A5 5A → mem[0x10]=A5, mem[0x11]=5A, and after cs_n rise RDSR returns 0x00.
- WREN then RDSR → 0x02 on every byte while cs_n stays low. WRDI then RDSR → 0x00.
- cs_n raised after 5 bits of a READ opcode, then a new READ 0x0002 → correct mem[2] returned; no residue from the aborted frame.
- rst_n asserted mid-READ_DATA → spi_cipo=0, spi_cipo_oe=0, busy=0 immediately; memory preserved; the next READ works. Unknown opcode 0xFF → spi_cipo stays 0 for the full frame.
